// File: rtl/otp_decryptor_rx.sv
// otp_decryptor_rx
// Receive end of the one-time-pad link. Regenerates the encryptor's pad stream
// with a lock-stepped Galois LFSR and XORs each ciphertext byte with it to recover
// plaintext. The last 8 pads are kept by index so a byte can be re-decrypted
// (replay) without disturbing the LFSR.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   start      one-cycle pulse: resynchronise (seed LFSR, clear history) and run
//   in_valid   / in_ready    input handshake (in_ready is combinational)
//   in_data    ciphertext byte
//   in_idx     pad index tagged by the encryptor
//   in_replay  1 = decrypt with stored pad for in_idx, no LFSR advance
//   out_valid  / out_ready   output handshake
//   out_data   plaintext byte
//   out_idx    index used for out_data
//   seq_err    sticky: a fresh byte arrived out of sequence
//   err_idx    in_idx of the first out-of-sequence byte
module otp_decryptor_rx #(
  parameter logic [7:0] SEED = 8'h01,
  parameter logic [7:0] TAPS = 8'hB8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [2:0] in_idx,
  input  logic       in_replay,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] out_idx,
  output logic       seq_err,
  output logic [2:0] err_idx
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t     state_reg, state_next;
  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_next;
  logic [2:0] exp_idx_reg;
  logic [7:0] pad_mem_reg [8];
  logic       out_valid_reg;
  logic [7:0] out_data_reg;
  logic [2:0] out_idx_reg;
  logic       seq_err_reg;
  logic [2:0] err_idx_reg;

  logic       accept;
  logic       fresh_ok;
  logic       fresh_bad;
  logic       replay_acc;
  logic [7:0] pad_sel;

  // Output register can take a new byte when empty or being drained this cycle.
  assign in_ready   = (state_reg == RUN) && !start && (!out_valid_reg || out_ready);
  assign accept     = in_valid && in_ready;
  assign fresh_ok   = accept && !in_replay && (in_idx == exp_idx_reg);
  assign fresh_bad  = accept && !in_replay && (in_idx != exp_idx_reg);
  assign replay_acc = accept && in_replay;

  assign lfsr_next = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? TAPS : 8'h00);
  assign pad_sel   = in_replay ? pad_mem_reg[in_idx] : lfsr_reg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN:     if (fresh_bad) state_next = ERR;
        default: state_next = state_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------- pad history
  // One register per slot: the history must clear in a single cycle on start.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pad_mem_reg[gi] <= 8'h00;
        end else if (start) begin
          pad_mem_reg[gi] <= 8'h00;
        end else if (fresh_ok && (in_idx == 3'(gi))) begin
          pad_mem_reg[gi] <= lfsr_reg;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_reg      <= SEED_EFF;
      exp_idx_reg   <= 3'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'h00;
      out_idx_reg   <= 3'd0;
      seq_err_reg   <= 1'b0;
      err_idx_reg   <= 3'd0;
    end else if (start) begin
      lfsr_reg      <= SEED_EFF;
      exp_idx_reg   <= 3'd0;
      out_valid_reg <= 1'b0;
      seq_err_reg   <= 1'b0;
      err_idx_reg   <= 3'd0;
    end else begin
      if (fresh_ok) begin
        lfsr_reg    <= lfsr_next;
        exp_idx_reg <= exp_idx_reg + 3'd1;
      end
      if (fresh_bad && !seq_err_reg) begin
        seq_err_reg <= 1'b1;
        err_idx_reg <= in_idx;
      end
      // A new byte reloads the register in the same cycle the old one drains.
      if (fresh_ok || replay_acc) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= in_data ^ pad_sel;
        out_idx_reg   <= in_idx;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_idx   = out_idx_reg;
  assign seq_err   = seq_err_reg;
  assign err_idx   = err_idx_reg;

endmodule

// File: tb/tb_otp_decryptor_rx.sv
module tb_otp_decryptor_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_idx;
  logic       in_replay;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_idx;
  logic       seq_err;
  logic [2:0] err_idx;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  m_lfsr;
  logic [7:0]  m_pad [8];
  logic [2:0]  m_exp;
  bit          m_run;
  bit          m_seq_err;
  logic [2:0]  m_err_idx;
  logic [10:0] q[$];       // pending outputs {idx, data}
  bit          last_acc;

  always #5 clk = ~clk;

  otp_decryptor_rx dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_idx(in_idx), .in_replay(in_replay),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .seq_err(seq_err), .err_idx(err_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return (l / 2) ^ ((l % 2 == 1) ? 8'hB8 : 8'h00);
  endfunction

  task automatic model_reset(input bit run);
    m_run = run; m_lfsr = 8'h01; m_exp = 3'd0;
    m_seq_err = 0; m_err_idx = 3'd0;
    for (int i = 0; i < 8; i++) m_pad[i] = 8'h00;
    q.delete();
  endtask

  task automatic model_accept();
    if (in_replay) begin
      q.push_back({in_idx, in_data ^ m_pad[in_idx]});
    end else if (in_idx == m_exp) begin
      q.push_back({in_idx, in_data ^ m_lfsr});
      m_pad[in_idx] = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
      m_exp = m_exp + 3'd1;
    end else begin
      if (!m_seq_err) begin m_seq_err = 1; m_err_idx = in_idx; end
      m_run = 0;
    end
  endtask

  // Called at a negedge with inputs set; predicts the coming posedge and checks after it.
  task automatic tick();
    bit exp_ready;
    #1;
    exp_ready = m_run && !start && (q.size() == 0 || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    last_acc = 0;
    if (start) begin
      model_reset(1);
    end else begin
      if (q.size() != 0 && out_ready) begin
        chk("out_data", 32'(out_data), 32'(q[0][7:0]));
        chk("out_idx", 32'(out_idx), 32'(q[0][10:8]));
        $display("xfer idx=%0d data=%02h", out_idx, out_data);
        void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
        last_acc = 1;
        model_accept();
      end
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("seq_err", 32'(seq_err), 32'(m_seq_err));
    if (m_seq_err) chk("err_idx", 32'(err_idx), 32'(m_err_idx));
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] i, input logic r);
    int n = 0;
    in_valid = 1; in_data = d; in_idx = i; in_replay = r;
    #1;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0; in_replay = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    reset = 1; start = 0; in_valid = 0; in_data = 0; in_idx = 0; in_replay = 0; out_ready = 1;
    model_reset(0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_err_idx", 32'(err_idx), 32'd0);
    reset = 0;
    // IDLE refuses bytes until start
    in_valid = 1; tick(); tick(); in_valid = 0;

    // Test 1: four fresh bytes
    pulse_start();
    send(8'h40, 3'd0, 0); chk("t1_b0", 32'(out_data), 32'h41);
    send(8'hF1, 3'd1, 0); chk("t1_b1", 32'(out_data), 32'h49);
    send(8'h35, 3'd2, 0); chk("t1_b2", 32'(out_data), 32'h69);
    send(8'h6C, 3'd3, 0); chk("t1_b3", 32'(out_data), 32'h42);
    chk("t1_idx", 32'(out_idx), 32'd3);

    // Test 3: replay then fresh idx 4 uses the 5th pad (17)
    send(8'hF1, 3'd1, 1); chk("t3_replay", 32'(out_data), 32'h49);
    send(8'h00, 3'd4, 0); chk("t3_fresh", 32'(out_data), 32'h17);
    tick();

    // Test 2: nine random fresh bytes with index wrap, then replay slot 0
    pulse_start();
    for (int k = 0; k < 9; k++) send(8'($urandom), 3'(k), 0);
    send(8'h00, 3'd0, 1); chk("t2_pad9", 32'(out_data), 32'h64);
    send(8'h00, 3'd1, 0); chk("t2_pad10", 32'(out_data), 32'h32);
    tick();

    // Test 4: sequence error then recovery
    pulse_start();
    send(8'hAA, 3'd2, 0);
    chk("t4_seq_err", 32'(seq_err), 32'd1);
    chk("t4_err_idx", 32'(err_idx), 32'd2);
    in_valid = 1; in_idx = 3'd0; tick(); in_valid = 0;
    pulse_start();
    chk("t4_cleared", 32'(seq_err), 32'd0);
    send(8'h40, 3'd0, 0); chk("t4_out", 32'(out_data), 32'h41);
    tick();

    // Test 5: backpressure then full-throughput streaming
    pulse_start();
    out_ready = 0;
    in_valid = 1; in_data = 8'($urandom); in_idx = m_exp;
    tick();
    held = out_data;
    in_data = 8'($urandom); in_idx = m_exp;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_hold", 32'(out_data), 32'(held));
    end
    out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_thru", 32'(last_acc), 32'd1);
      in_data = 8'($urandom); in_idx = m_exp;
    end
    in_valid = 0;
    tick(); tick();

    // Test 6: asynchronous reset with a pending output
    out_ready = 0;
    send(8'h55, m_exp, 0);
    #2 reset = 1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd0);
    model_reset(0);
    @(negedge clk);
    reset = 0; out_ready = 1;
    in_valid = 1; in_idx = 3'd0; tick(); tick(); in_valid = 0;
    pulse_start();
    send(8'h40, 3'd0, 0); chk("t6_out", 32'(out_data), 32'h41);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
